calculator_button_conditioner: RTL and testbench
================================================

Name: calculator_button_conditioner

Overview:
- Input-side counterpart of the calculator's seven-segment display path: turns the five raw, bouncy push-buttons (btnC, btnU, btnD, btnL, btnR) into clean levels and single-cycle event pulses.
- Downstream users are the stage selector (left/right), the display digit/scroll control (up/down/center) and the data collector.
- Each button is synchronised and debounced independently; each also has an optional hold-to-repeat generator.

Parameters:
- NUM_BTN, 5, number of buttons. Bit order: 0=btnC, 1=btnU, 2=btnD, 3=btnL, 4=btnR.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a new level (10 ms at 100 MHz).
- REPEAT_DELAY_CYCLES, 50000000, hold time from accepted press to first repeat pulse (0.5 s).
- REPEAT_RATE_CYCLES, 10000000, period between subsequent repeat pulses (0.1 s).
- CNT_W, 26, counter width. Must hold max(all cycle parameters)-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_raw  in  NUM_BTN  raw button inputs, asynchronous to clk.
- btn_level  out  NUM_BTN  debounced level per button.
- btn_press  out  NUM_BTN  one-cycle pulse on each accepted 0->1 transition.
- btn_release  out  NUM_BTN  one-cycle pulse on each accepted 1->0 transition.
- btn_action  out  NUM_BTN  one-cycle pulse on press or auto-repeat; this is what consumers step on.

Behaviour:
- Reset (async assert; release is synchronous to clk): all sync flops, stable levels, counters and FSMs are cleared. All outputs are 0.
- Synchroniser: a 2-FF chain per bit, reset to 0. No logic sits between the two flops.
- Debounce, per bit:
  - When sync output != stable, the counter increments.
  - When they are equal, the counter clears, so any glitch restarts the count.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, stable takes the sync value and the counter clears.
  - btn_level = stable.
- Edge pulses:
  - btn_press = stable & ~stable_d, and btn_release = ~stable & stable_d, where stable_d is a registered copy of stable. Each is exactly one cycle wide.
  - Latency: the first clk edge sampling a new clean raw level is edge k. btn_level changes after edge k+1+DEBOUNCE_CYCLES. btn_press or btn_release is high during the cycle following that change.
- Repeat FSM, per bit, states IDLE / DELAY / REPEAT:
  - IDLE: on btn_press go to DELAY with the counter cleared.
  - DELAY: the counter increments each cycle. At REPEAT_DELAY_CYCLES-1, emit a repeat pulse, clear the counter and go to REPEAT.
  - REPEAT: at REPEAT_RATE_CYCLES-1, emit a repeat pulse and clear the counter.
  - From any state, stable=0 forces IDLE with the counter cleared. A release wins over a same-cycle repeat, and no pulse is emitted.
- btn_action = btn_press | repeat pulse. A press and a repeat never coincide.
- Buttons are fully independent. Simultaneous presses on several bits yield simultaneous pulses with no arbitration.
- Reset during a hold: outputs drop to 0 immediately. If the button is still held after reset release, it is re-debounced and produces a fresh btn_press.
- Counters saturate-free by construction: they clear before overflow, given the CNT_W rule above.

Optional Feature:
- Macro: CALC_BTN_AUTO_REPEAT_EN.
- Defined: the repeat FSMs and counters are built, and btn_action behaves as above.
- Undefined: no repeat logic is synthesised, btn_action = btn_press, and the REPEAT_* parameters are ignored.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=5, macro defined):
- Clean press: btn_raw[1] 0->1 sampled at edge k -> btn_level[1]=1 after edge k+5; btn_press[1] and btn_action[1] high for exactly one cycle; other bits stay 0.
- Bounce: btn_raw[3] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pulse during bouncing; a single btn_press[3] at 6 cycles after the last toggle is sampled.
- Hold 60 cycles after the accepted press on bit 2 -> btn_action[2] pulses at +0 (press), then at +20, +25, +30, ..., +55; btn_release[2] on let-go, and no further action pulses.
- Simultaneous: btn_raw=5'b10001 in one cycle -> btn_press=5'b10001 in the same cycle.
- Reset mid-hold: rst pulse at +10 during a held bit 0 -> outputs 0 at once; after release, a new btn_press[0] arrives 5 cycles after the first post-reset sample.
- Macro undefined: 60-cycle hold -> exactly one btn_action pulse, coincident with btn_press.

Source files
------------

// File: rtl/calculator_button_conditioner.sv
// Push-button conditioner: 2-FF sync, per-bit debounce, edge pulses and optional hold-to-repeat.
// Auto-repeat is built only when CALC_BTN_AUTO_REPEAT_EN is defined; otherwise btn_action = press.
module calculator_button_conditioner #(
    parameter int unsigned NUM_BTN             = 5,
    parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 50000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 10000000,
    parameter int unsigned CNT_W               = 26
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_raw_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic [NUM_BTN-1:0] btn_action_o
);

    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic             stable_q, stable_d;
        logic             stable_dly_q;
        logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
        logic             press;
        logic             release_p;

        // Any sample that agrees with the stable level restarts the count.
        always_comb begin
            stable_d  = stable_q;
            deb_cnt_d = '0;
            if (sync2_q[i] != stable_q) begin
                if (deb_cnt_q == DebLast) begin
                    stable_d = sync2_q[i];
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stable_q     <= 1'b0;
                stable_dly_q <= 1'b0;
                deb_cnt_q    <= '0;
            end else begin
                stable_q     <= stable_d;
                stable_dly_q <= stable_q;
                deb_cnt_q    <= deb_cnt_d;
            end
        end

        assign press     = stable_q & ~stable_dly_q;
        assign release_p = ~stable_q & stable_dly_q;

        assign btn_level_o[i]   = stable_q;
        assign btn_press_o[i]   = press;
        assign btn_release_o[i] = release_p;

`ifdef CALC_BTN_AUTO_REPEAT_EN
        localparam logic [1:0] StIdle   = 2'd0;
        localparam logic [1:0] StDelay  = 2'd1;
        localparam logic [1:0] StRepeat = 2'd2;

        localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY_CYCLES - 1);
        localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE_CYCLES - 1);

        logic [1:0]       rpt_state_q, rpt_state_d;
        logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic             rpt_pulse;

        // A low stable level overrides everything, so a release never emits a repeat.
        always_comb begin
            rpt_state_d = rpt_state_q;
            rpt_cnt_d   = rpt_cnt_q;
            rpt_pulse   = 1'b0;
            if (!stable_q) begin
                rpt_state_d = StIdle;
                rpt_cnt_d   = '0;
            end else begin
                case (rpt_state_q)
                    StIdle: begin
                        if (press) begin
                            rpt_state_d = StDelay;
                            rpt_cnt_d   = '0;
                        end
                    end
                    StDelay: begin
                        if (rpt_cnt_q == DelayLast) begin
                            rpt_pulse   = 1'b1;
                            rpt_cnt_d   = '0;
                            rpt_state_d = StRepeat;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                        end
                    end
                    StRepeat: begin
                        if (rpt_cnt_q == RateLast) begin
                            rpt_pulse = 1'b1;
                            rpt_cnt_d = '0;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        rpt_state_d = StIdle;
                        rpt_cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rpt_state_q <= StIdle;
                rpt_cnt_q   <= '0;
            end else begin
                rpt_state_q <= rpt_state_d;
                rpt_cnt_q   <= rpt_cnt_d;
            end
        end

        assign btn_action_o[i] = press | rpt_pulse;
`else
        assign btn_action_o[i] = press;
`endif
    end

`ifndef CALC_BTN_AUTO_REPEAT_EN
    // Repeat timing parameters have no effect in this build.
    if (REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_repeat_cfg_unused
    end
`endif

endmodule

// File: tb/tb_calculator_button_conditioner.sv
// Directed bench for calculator_button_conditioner with short debounce and repeat timings.
// Expectations follow CALC_BTN_AUTO_REPEAT_EN so the bench serves both builds.
module tb_calculator_button_conditioner;

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic [4:0] btn_action;

    int n_assert;
    int n_fail;

    calculator_button_conditioner #(
        .NUM_BTN            (5),
        .DEBOUNCE_CYCLES    (4),
        .REPEAT_DELAY_CYCLES(20),
        .REPEAT_RATE_CYCLES (5),
        .CNT_W              (26)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .btn_raw_i    (btn_raw),
        .btn_level_o  (btn_level),
        .btn_press_o  (btn_press),
        .btn_release_o(btn_release),
        .btn_action_o (btn_action)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] exp_act;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        btn_raw  = 5'b00000;

        // Reset state
        tick(3);
        chk("rst_level", btn_level, 5'b00000);
        chk("rst_press", btn_press, 5'b00000);
        chk("rst_release", btn_release, 5'b00000);
        chk("rst_action", btn_action, 5'b00000);
        rst = 1'b0;
        tick(3);

        // Clean press on bit 1: level and press appear on the 6th edge after the change
        btn_raw = 5'b00010;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            chk("clean_level", btn_level, (c >= 6) ? 5'b00010 : 5'b00000);
            chk("clean_press", btn_press, (c == 6) ? 5'b00010 : 5'b00000);
            chk("clean_action", btn_action, (c == 6) ? 5'b00010 : 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            chk("clean_release", btn_release, (c == 6) ? 5'b00010 : 5'b00000);
            chk("clean_rel_action", btn_action, 5'b00000);
        end
        tick(2);

        // Bounce on bit 3: no pulses until the final level has held long enough
        for (int t = 0; t < 4; t++) begin
            btn_raw = (t % 2 == 0) ? 5'b01000 : 5'b00000;
            for (int c = 0; c < 2; c++) begin
                tick(1);
                chk("bounce_quiet", btn_press, 5'b00000);
            end
        end
        btn_raw = 5'b01000;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            chk("bounce_press", btn_press, (c == 6) ? 5'b01000 : 5'b00000);
        end
        btn_raw = 5'b00000;
        tick(10);
        chk("bounce_released", btn_level, 5'b00000);

        // Hold on bit 2; letting go at +54 makes the level drop at +60, suppressing that repeat
        btn_raw = 5'b00100;
        tick(6);
        chk("hold_press", btn_press, 5'b00100);
        chk("hold_action0", btn_action, 5'b00100);
        for (int m = 1; m <= 66; m++) begin
            tick(1);
`ifdef CALC_BTN_AUTO_REPEAT_EN
            exp_act = (m >= 20 && m <= 55 && (m - 20) % 5 == 0) ? 5'b00100 : 5'b00000;
`else
            exp_act = 5'b00000;
`endif
            chk("hold_action", btn_action, exp_act);
            chk("hold_release", btn_release, (m == 60) ? 5'b00100 : 5'b00000);
            if (m == 54) btn_raw = 5'b00000;
        end
        tick(2);

        // Simultaneous press on bits 0 and 4
        btn_raw = 5'b10001;
        tick(5);
        chk("simul_pre", btn_press, 5'b00000);
        tick(1);
        chk("simul_press", btn_press, 5'b10001);
        chk("simul_action", btn_action, 5'b10001);
        tick(1);
        chk("simul_post", btn_press, 5'b00000);
        btn_raw = 5'b00001;
        tick(9);
        chk("midhold_level", btn_level, 5'b00001);

        // Reset during a hold clears outputs immediately, then bit 0 re-debounces
        rst = 1'b1;
        #1;
        chk("midrst_level", btn_level, 5'b00000);
        chk("midrst_press", btn_press, 5'b00000);
        chk("midrst_action", btn_action, 5'b00000);
        tick(2);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            chk("rerst_press", btn_press, (c == 6) ? 5'b00001 : 5'b00000);
            chk("rerst_level", btn_level, (c >= 6) ? 5'b00001 : 5'b00000);
        end
        btn_raw = 5'b00000;
        tick(10);
        chk("final_level", btn_level, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
